// File: rtl/pp3_logic_pkg.sv
// Shared types and helpers for the PP3 logic-cell register side.
// Build option: PP3_QFRAG_RB_PARITY_EN appends an even-parity bit to readback.
package pp3_logic_pkg;

   typedef enum logic [1:0] {IDLE, LEAD, SHIFT, DONE} rb_state_t;

   localparam string MODE_SINGLE = "SINGLE";
   localparam string MODE_SPLIT  = "SPLIT";

`ifdef PP3_QFRAG_RB_PARITY_EN
   localparam int RB_PAR = 1;
`else
   localparam int RB_PAR = 0;
`endif

   // Number of functional flops exposed to readback for a given cell mode
   function automatic int rb_nbits(string mode);
      return (mode == MODE_SPLIT) ? 2 : 1;
   endfunction

endpackage

// File: rtl/q_frag_rb_fsm.sv
// Readback engine: snapshots the cell flops into a shadow register on a
// 4-phase request, optionally waits RB_LEAD cycles, shifts the shadow out
// LSB first, then holds ACK until the request is withdrawn.
// Build option: PP3_QFRAG_RB_PARITY_EN (via pp3_logic_pkg::RB_PAR).
module q_frag_rb_fsm
   import pp3_logic_pkg::*;
#(
   parameter int NB      = 1,
   parameter int RB_LEAD = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rb_req,
   input  logic [NB-1:0] ff,
   output logic          rb_dv,
   output logic          rb_do,
   output logic          rb_ack
);
   localparam int NBT = NB + RB_PAR;
   localparam int BW  = $clog2(NB + 2);
   localparam logic [2:0]    LEAD_LAST = (RB_LEAD > 0) ? 3'(RB_LEAD - 1) : 3'd0;
   localparam logic [BW-1:0] BIT_LAST  = BW'(NBT - 1);

   rb_state_t        state_q, state_d;
   logic [2:0]       lead_q, lead_d;
   logic [BW-1:0]    bit_q, bit_d;
   logic [NBT-1:0]   shadow_q, shadow_d;
   logic [NBT-1:0]   snap;

   // Snapshot image: data flops in the low bits, parity (if built) on top
   always_comb begin
      snap = '0;
      snap[NB-1:0] = ff;
      if (RB_PAR != 0) snap[NBT-1] = ^ff;
   end

   // Next-state: request drop aborts LEAD/SHIFT; SHIFT exits on terminal count
   always_comb begin
      state_d  = state_q;
      lead_d   = lead_q;
      bit_d    = bit_q;
      shadow_d = shadow_q;
      case (state_q)
         IDLE: begin
            if (rb_req) begin
               shadow_d = snap;
               lead_d   = '0;
               bit_d    = '0;
               state_d  = (RB_LEAD > 0) ? LEAD : SHIFT;
            end
         end
         LEAD: begin
            if (!rb_req)                 state_d = IDLE;
            else if (lead_q == LEAD_LAST) state_d = SHIFT;
            else                         lead_d  = lead_q + 3'd1;
         end
         SHIFT: begin
            if (!rb_req) begin
               state_d = IDLE;
            end else begin
               shadow_d = shadow_q >> 1;
               if (bit_q == BIT_LAST) state_d = DONE;
               else                   bit_d   = bit_q + 1'b1;
            end
         end
         DONE: begin
            if (!rb_req) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters and shadow registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         lead_q   <= '0;
         bit_q    <= '0;
         shadow_q <= '0;
      end else begin
         state_q  <= state_d;
         lead_q   <= lead_d;
         bit_q    <= bit_d;
         shadow_q <= shadow_d;
      end
   end

   assign rb_dv  = (state_q == SHIFT);
   assign rb_do  = rb_dv & shadow_q[0];
   assign rb_ack = (state_q == DONE);

endmodule

// File: rtl/q_frag_capture.sv
// Register side of the PP3 logic cell: FF0 (CZ or QDI), optional FF1 (TZ)
// in SPLIT mode, shared set/enable, and a serial readback port.
// Build option: PP3_QFRAG_RB_PARITY_EN adds an even-parity readback bit.
module q_frag_capture
   import pp3_logic_pkg::*;
#(
   parameter string MODE    = "SINGLE",
   parameter int    RB_LEAD = 1
) (
   input  logic QCK,
   input  logic QRT,
   input  logic CZ,
   input  logic TZ,
   input  logic QDI,
   input  logic QDS,
   input  logic QEN,
   input  logic QST,
   output logic QZ,
   output logic TQZ,
   input  logic RB_REQ,
   output logic RB_DV,
   output logic RB_DO,
   output logic RB_ACK
);
   localparam int NB = rb_nbits(MODE);

   logic          ff0_q, ff0_d;
   logic [NB-1:0] ff_vec;

   // FF0 next value: set beats enable; D is QDI when bypassing the fragment
   always_comb begin
      ff0_d = ff0_q;
      if (QST)      ff0_d = 1'b1;
      else if (QEN) ff0_d = QDS ? QDI : CZ;
   end

   // FF0 register; reset overrides set/enable
   always_ff @(posedge QCK) begin
      if (QRT) ff0_q <= 1'b0;
      else     ff0_q <= ff0_d;
   end

   assign QZ = ff0_q;

   if (NB == 2) begin : g_split
      logic ff1_q, ff1_d;

      // FF1 next value: same set/enable as FF0, data from the top fragment
      always_comb begin
         ff1_d = ff1_q;
         if (QST)      ff1_d = 1'b1;
         else if (QEN) ff1_d = TZ;
      end

      // FF1 register
      always_ff @(posedge QCK) begin
         if (QRT) ff1_q <= 1'b0;
         else     ff1_q <= ff1_d;
      end

      assign TQZ    = ff1_q;
      assign ff_vec = {ff1_q, ff0_q};
   end else begin : g_single
      logic unused_tz;
      assign unused_tz = TZ;
      assign TQZ       = 1'b0;
      assign ff_vec    = ff0_q;
   end

   q_frag_rb_fsm #(
      .NB      (NB),
      .RB_LEAD (RB_LEAD)
   ) u_rb (
      .clk    (QCK),
      .rst    (QRT),
      .rb_req (RB_REQ),
      .ff     (ff_vec),
      .rb_dv  (RB_DV),
      .rb_do  (RB_DO),
      .rb_ack (RB_ACK)
   );

endmodule

// File: tb/tb_q_frag_capture.sv
// Bench for q_frag_capture: a SINGLE/RB_LEAD=0 and a SPLIT/RB_LEAD=1 instance
// share the same stimulus and are both checked against a timeline model.
module tb_q_frag_capture;

`ifdef PP3_QFRAG_RB_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic qrt, cz, tz, qdi, qds, qen, qst, rb_req;
   logic [1:0] qz, tqz, dv, dout, ack;

   int  total = 0;
   int  bad   = 0;
   bit  chk_on = 1'b0;

   q_frag_capture #(.MODE("SINGLE"), .RB_LEAD(0)) u_s (
      .QCK(clk), .QRT(qrt), .CZ(cz), .TZ(tz), .QDI(qdi), .QDS(qds), .QEN(qen), .QST(qst),
      .QZ(qz[0]), .TQZ(tqz[0]), .RB_REQ(rb_req), .RB_DV(dv[0]), .RB_DO(dout[0]), .RB_ACK(ack[0]));

   q_frag_capture #(.MODE("SPLIT"), .RB_LEAD(1)) u_p (
      .QCK(clk), .QRT(qrt), .CZ(cz), .TZ(tz), .QDI(qdi), .QDS(qds), .QEN(qen), .QST(qst),
      .QZ(qz[1]), .TQZ(tqz[1]), .RB_REQ(rb_req), .RB_DV(dv[1]), .RB_DO(dout[1]), .RB_ACK(ack[1]));

   // ---------------- reference model ----------------
   // Readback is modelled as a timeline: t counts cycles since the snapshot;
   // the first lead cycles are dead, the next n cycles carry bits[t-lead].
   function automatic int lead_of(int i); return (i == 0) ? 0 : 1; endfunction
   function automatic int nb_of(int i);   return (i == 0) ? 1 : 2; endfunction

   bit m_qz[2], m_tqz[2], m_busy[2], m_ack[2];
   int m_t[2], m_n[2];
   bit m_bits[2][3];
   bit o0, o1;

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         o0 = m_qz[i];
         o1 = m_tqz[i];
         if (qrt) begin
            m_qz[i] = 1'b0; m_tqz[i] = 1'b0; m_busy[i] = 1'b0; m_ack[i] = 1'b0;
         end else begin
            if (m_ack[i]) begin
               if (!rb_req) m_ack[i] = 1'b0;
            end else if (m_busy[i]) begin
               if (!rb_req) m_busy[i] = 1'b0;
               else begin
                  m_t[i]++;
                  if (m_t[i] == lead_of(i) + m_n[i]) begin
                     m_busy[i] = 1'b0; m_ack[i] = 1'b1;
                  end
               end
            end else if (rb_req) begin
               m_busy[i] = 1'b1;
               m_t[i]    = 0;
               m_n[i]    = nb_of(i) + PAR;
               m_bits[i][0] = o0;
               m_bits[i][1] = (nb_of(i) == 2) ? o1 : (o0);
               m_bits[i][2] = o0 ^ o1;
            end
            if (qst)      m_qz[i] = 1'b1;
            else if (qen) m_qz[i] = qds ? qdi : cz;
            if (nb_of(i) == 2) begin
               if (qst)      m_tqz[i] = 1'b1;
               else if (qen) m_tqz[i] = tz;
            end
         end
      end
   end

   function automatic bit e_dv(int i);
      return m_busy[i] && (m_t[i] >= lead_of(i));
   endfunction
   function automatic bit e_do(int i);
      return e_dv(i) ? m_bits[i][m_t[i] - lead_of(i)] : 1'b0;
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("cyc qz[%0d]", i),   qz[i],   m_qz[i]);
            chk($sformatf("cyc tqz[%0d]", i),  tqz[i],  m_tqz[i]);
            chk($sformatf("cyc rb_dv[%0d]", i), dv[i],  e_dv(i));
            chk($sformatf("cyc rb_do[%0d]", i), dout[i], e_do(i));
            chk($sformatf("cyc rb_ack[%0d]", i), ack[i], m_ack[i]);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Single-instance parity literal for SINGLE in the first readback: FF0=1
   // ---------------- directed stimulus ----------------
   initial begin
      qrt = 1'b1; cz = 1'b0; tz = 1'b0; qdi = 1'b0; qds = 1'b0;
      qen = 1'b0; qst = 1'b0; rb_req = 1'b0;
      step(1);
      chk_on = 1'b1;
      step(1);
      chk("rst qz", qz[1], 1'b0);
      chk("rst ack", ack[1], 1'b0);
      chk("rst dv", dv[1], 1'b0);

      // Capture CZ, then hold with enable low
      qrt = 1'b0; qen = 1'b1; cz = 1'b1;
      step(1);
      chk("cap qz", qz[0], 1'b1);
      qen = 1'b0; cz = 1'b0;
      step(2);
      chk("hold qz", qz[0], 1'b1);
      chk("single tqz", tqz[0], 1'b0);

      // Reset beats set; then set alone
      qrt = 1'b1; qst = 1'b1;
      step(1);
      chk("rst>set qz", qz[0], 1'b0);
      qrt = 1'b0;
      step(1);
      chk("set qz", qz[0], 1'b1);
      chk("set tqz", tqz[1], 1'b1);
      qst = 1'b0;

      // SPLIT readback with FF0=1, FF1=0
      qen = 1'b1; cz = 1'b1; tz = 1'b0;
      step(1);
      qen = 1'b0;
      chk("pre rb tqz", tqz[1], 1'b0);
      rb_req = 1'b1;
      step(1);
      chk("rb1 lead dv", dv[1], 1'b0);
      chk("rb1 s dv", dv[0], 1'b1);
      chk("rb1 s do", dout[0], 1'b1);
      step(1);
      chk("rb1 b0 dv", dv[1], 1'b1);
      chk("rb1 b0 do", dout[1], 1'b1);
      step(1);
      chk("rb1 b1 dv", dv[1], 1'b1);
      chk("rb1 b1 do", dout[1], 1'b0);
      step(1);
`ifdef PP3_QFRAG_RB_PARITY_EN
      chk("rb1 par dv", dv[1], 1'b1);
      chk("rb1 par do", dout[1], 1'b1);
      step(1);
`endif
      chk("rb1 ack", ack[1], 1'b1);
      chk("rb1 done dv", dv[1], 1'b0);
      step(2);
      chk("rb1 ack hold", ack[1], 1'b1);
      rb_req = 1'b0;
      step(1);
      chk("rb1 ack drop", ack[1], 1'b0);

      // SPLIT readback with FF0=FF1=1, FF0 loaded through the QDI bypass
      qen = 1'b1; qds = 1'b1; qdi = 1'b1; cz = 1'b0; tz = 1'b1;
      step(1);
      qen = 1'b0; qds = 1'b0;
      rb_req = 1'b1;
      step(2);
      chk("rb2 b0 do", dout[1], 1'b1);
      step(1);
      chk("rb2 b1 do", dout[1], 1'b1);
      step(1);
`ifdef PP3_QFRAG_RB_PARITY_EN
      chk("rb2 par dv", dv[1], 1'b1);
      chk("rb2 par do", dout[1], 1'b0);
      step(1);
`endif
      chk("rb2 ack", ack[1], 1'b1);
      rb_req = 1'b0;
      step(1);

      // Abort during the first SHIFT bit
      rb_req = 1'b1;
      step(2);
      chk("abort b0 dv", dv[1], 1'b1);
      rb_req = 1'b0;
      step(1);
      chk("abort dv", dv[1], 1'b0);
      chk("abort ack", ack[1], 1'b0);
      step(3);
      chk("abort no ack", ack[1], 1'b0);

      // Reset in DONE, then a request held across reset release snapshots 0s
      qen = 1'b1; cz = 1'b1; tz = 1'b1;
      step(1);
      rb_req = 1'b1;
      step(2 + 2 + PAR);
      chk("done ack", ack[1], 1'b1);
      qrt = 1'b1;
      step(1);
      chk("qrt ack", ack[1], 1'b0);
      chk("qrt qz", qz[1], 1'b0);
      qrt = 1'b0;
      step(1);
      chk("post qrt lead dv", dv[1], 1'b0);
      chk("post qrt qz", qz[1], 1'b1);
      step(1);
      chk("zero b0 dv", dv[1], 1'b1);
      chk("zero b0 do", dout[1], 1'b0);
      step(1);
      chk("zero b1 do", dout[1], 1'b0);
      rb_req = 1'b0;
      qen = 1'b0;
      step(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
